// File: rtl/line_seq_pkg.sv
// Shared types and width helpers for the vertical-pass line pair sequencer.
//   state_t      : sequencer phase (idle, top extension, body, bottom extension)
//   ext_width()  : bit width needed to carry an extension depth up to max_ext
//   ch_width()   : bit width of a channel index for max_ch channels (min 1)
//   EXT_53/97    : extension depths of the 5/3 and 9/7 lifting filters
package line_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TOP,
    ST_BODY,
    ST_BOTTOM
  } state_t;

  localparam int unsigned EXT_53 = 2;
  localparam int unsigned EXT_97 = 4;

  function automatic int unsigned ext_width(input int unsigned max_ext);
    return $clog2(max_ext + 1);
  endfunction

  function automatic int unsigned ch_width(input int unsigned max_ch);
    return (max_ch > 1) ? $clog2(max_ch) : 1;
  endfunction

endpackage

// File: rtl/line_pair_sequencer_mirror.sv
// Whole-sample symmetric mirror of a virtual line index, scaled to full
// resolution by the decomposition level.
//   v        : signed virtual index (may lie outside 0..last_idx)
//   last_idx : last valid line index at this level (N-1)
//   lvl      : decomposition level; result is shifted left by this amount
//   line     : mirrored, shifted line number
module line_mirror #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LVL_W  = 3
) (
  input  logic signed [ADDR_W:0]   v,
  input  logic        [ADDR_W-1:0] last_idx,
  input  logic        [LVL_W-1:0]  lvl,
  output logic        [ADDR_W-1:0] line
);

  logic signed [ADDR_W+1:0] vx;
  logic signed [ADDR_W+1:0] nx;
  logic signed [ADDR_W+1:0] mx;

  always_comb begin
    vx = $signed({v[ADDR_W], v});
    nx = $signed({2'b00, last_idx});
    if (v[ADDR_W]) begin
      mx = -vx;
    end else if (vx > nx) begin
      mx = (nx <<< 1) - vx;
    end else begin
      mx = vx;
    end
    line = ADDR_W'(mx) << lvl;
  end

endmodule

// File: rtl/line_pair_sequencer.sv
// Emits the (even, odd) full-resolution line pairs fetched for one vertical
// DWT pass, with whole-sample symmetric extension at both edges, repeated
// for every channel.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   start_i            : frame start, honoured only while idle
//   abort_i            : drop the current sequence
//   vsize_i            : lines at this level minus one (N-1)
//   ext_i              : extension depth E
//   level_i            : decomposition level L
//   channels_i         : channel count minus one
//   ready_i            : consumer accepts the current pair
//   valid_o            : pair valid
//   even_line_num_o    : even sample line, odd_line_num_o : odd sample line
//   ch_o               : channel of the current pair
//   last_line_o        : last pair of the channel, last_frame_o : of the frame
//   busy_o             : sequence in progress
//   cfg_err_o          : one-cycle pulse for a rejected start
module line_pair_sequencer
  import line_seq_pkg::*;
#(
  parameter  int unsigned ADDR_W    = 32,
  parameter  int unsigned MAX_EXT   = 5,
  parameter  int unsigned MAX_LEVEL = 5,
  parameter  int unsigned MAX_CH    = 4,
  localparam int unsigned EXT_W     = ext_width(MAX_EXT),
  localparam int unsigned LVL_W     = $clog2(MAX_LEVEL + 1),
  localparam int unsigned CH_W      = ch_width(MAX_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] vsize_i,
  input  logic [EXT_W-1:0]  ext_i,
  input  logic [LVL_W-1:0]  level_i,
  input  logic [CH_W-1:0]   channels_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] even_line_num_o,
  output logic [ADDR_W-1:0] odd_line_num_o,
  output logic [CH_W-1:0]   ch_o,
  output logic              last_line_o,
  output logic              last_frame_o,
  output logic              busy_o,
  output logic              cfg_err_o
);

  state_t                   state;
  logic signed [ADDR_W:0]   v_r;
  logic        [ADDR_W-1:0] nm1_r;
  logic        [EXT_W-1:0]  ext_r;
  logic        [LVL_W-1:0]  lvl_r;
  logic        [CH_W-1:0]   chmax_r;

  logic                     idle;
  logic        [ADDR_W-1:0] nm1_sel;
  logic        [EXT_W-1:0]  ext_sel;
  logic        [LVL_W-1:0]  lvl_sel;
  logic signed [ADDR_W:0]   nv0;
  logic signed [ADDR_W:0]   nv1;
  logic signed [ADDR_W+1:0] nv1_x;
  logic signed [ADDR_W+1:0] nm1_x;
  logic signed [ADDR_W+1:0] lim;
  logic                     nxt_last;
  state_t                   nxt_state;
  logic                     cfg_bad;
  logic                     accept;
  logic        [CH_W-1:0]   ch_nxt;
  logic        [ADDR_W-1:0] ne_line;
  logic        [ADDR_W-1:0] no_line;

  assign idle = (state == ST_IDLE);

  // The next pair is prepared combinationally: while idle it comes from the
  // live config inputs (first pair of a start), otherwise from the latched
  // config, restarting at -E after the last pair of a channel.
  always_comb begin
    nm1_sel = idle ? vsize_i : nm1_r;
    ext_sel = idle ? ext_i   : ext_r;
    lvl_sel = idle ? level_i : lvl_r;
    if (idle || last_line_o) begin
      nv0 = -$signed((ADDR_W+1)'(ext_sel));
    end else begin
      nv0 = v_r + (ADDR_W+1)'(2);
    end
    nv1      = nv0 + (ADDR_W+1)'(1);
    nv1_x    = $signed({nv1[ADDR_W], nv1});
    nm1_x    = $signed({2'b00, nm1_sel});
    lim      = nm1_x + $signed({{(ADDR_W+2-EXT_W){1'b0}}, ext_sel});
    nxt_last = (nv1_x >= lim);
    if (nv0[ADDR_W]) begin
      nxt_state = ST_TOP;
    end else if (nv1_x <= nm1_x) begin
      nxt_state = ST_BODY;
    end else begin
      nxt_state = ST_BOTTOM;
    end
    cfg_bad = (vsize_i == '0) || (ADDR_W'(ext_i) >= vsize_i) ||
              (ext_i > EXT_W'(MAX_EXT)) || (level_i > LVL_W'(MAX_LEVEL));
    accept  = valid_o && ready_i;
    ch_nxt  = last_line_o ? ch_o + CH_W'(1) : ch_o;
  end

  line_mirror #(.ADDR_W(ADDR_W), .LVL_W(LVL_W)) u_mir_even (
    .v        (nv0),
    .last_idx (nm1_sel),
    .lvl      (lvl_sel),
    .line     (ne_line)
  );

  line_mirror #(.ADDR_W(ADDR_W), .LVL_W(LVL_W)) u_mir_odd (
    .v        (nv1),
    .last_idx (nm1_sel),
    .lvl      (lvl_sel),
    .line     (no_line)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      v_r             <= '0;
      nm1_r           <= '0;
      ext_r           <= '0;
      lvl_r           <= '0;
      chmax_r         <= '0;
      valid_o         <= 1'b0;
      even_line_num_o <= '0;
      odd_line_num_o  <= '0;
      ch_o            <= '0;
      last_line_o     <= 1'b0;
      last_frame_o    <= 1'b0;
      busy_o          <= 1'b0;
      cfg_err_o       <= 1'b0;
    end else begin
      cfg_err_o <= 1'b0;
      if (idle) begin
        if (start_i) begin
          if (cfg_bad) begin
            cfg_err_o <= 1'b1;
          end else begin
            nm1_r           <= vsize_i;
            ext_r           <= ext_i;
            lvl_r           <= level_i;
            chmax_r         <= channels_i;
            v_r             <= nv0;
            state           <= nxt_state;
            valid_o         <= 1'b1;
            busy_o          <= 1'b1;
            even_line_num_o <= ne_line;
            odd_line_num_o  <= no_line;
            ch_o            <= '0;
            last_line_o     <= nxt_last;
            last_frame_o    <= nxt_last && (channels_i == '0);
          end
        end
      end else if (abort_i || (accept && last_frame_o)) begin
        state        <= ST_IDLE;
        valid_o      <= 1'b0;
        busy_o       <= 1'b0;
        last_line_o  <= 1'b0;
        last_frame_o <= 1'b0;
      end else if (accept) begin
        v_r             <= nv0;
        state           <= nxt_state;
        even_line_num_o <= ne_line;
        odd_line_num_o  <= no_line;
        ch_o            <= ch_nxt;
        last_line_o     <= nxt_last;
        last_frame_o    <= nxt_last && (ch_nxt == chmax_r);
      end
    end
  end

endmodule

// File: tb/tb_line_pair_sequencer.sv
module tb_line_pair_sequencer;
  import line_seq_pkg::*;

  localparam int ADDR_W = 32;
  localparam int EXT_W  = 3;
  localparam int LVL_W  = 3;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              abort_i;
  logic [ADDR_W-1:0] vsize_i;
  logic [EXT_W-1:0]  ext_i;
  logic [LVL_W-1:0]  level_i;
  logic [CH_W-1:0]   channels_i;
  logic              ready_i;
  logic              valid_o;
  logic [ADDR_W-1:0] even_line_num_o;
  logic [ADDR_W-1:0] odd_line_num_o;
  logic [CH_W-1:0]   ch_o;
  logic              last_line_o;
  logic              last_frame_o;
  logic              busy_o;
  logic              cfg_err_o;

  always #5 clk = ~clk;

  line_pair_sequencer #(
    .ADDR_W(ADDR_W), .MAX_EXT(5), .MAX_LEVEL(5), .MAX_CH(4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .vsize_i         (vsize_i),
    .ext_i           (ext_i),
    .level_i         (level_i),
    .channels_i      (channels_i),
    .ready_i         (ready_i),
    .valid_o         (valid_o),
    .even_line_num_o (even_line_num_o),
    .odd_line_num_o  (odd_line_num_o),
    .ch_o            (ch_o),
    .last_line_o     (last_line_o),
    .last_frame_o    (last_frame_o),
    .busy_o          (busy_o),
    .cfg_err_o       (cfg_err_o)
  );

  typedef struct {
    int unsigned even;
    int unsigned odd;
    int unsigned ch;
    bit          ll;
    bit          lf;
  } pair_t;

  pair_t q[$];
  pair_t mon_exp;
  int    checks = 0;
  int    errors = 0;

  function automatic int mirror(input int x, input int nm1);
    if (x < 0) return -x;
    if (x > nm1) return 2 * nm1 - x;
    return x;
  endfunction

  // Reference: ceil((N+2E)/2) pairs per channel, v = -E + 2k.
  task automatic push_model(input int nm1, input int e, input int l, input int chm);
    int n;
    int cnt;
    n   = nm1 + 1;
    cnt = (n + 2 * e + 1) / 2;
    for (int c = 0; c <= chm; c++) begin
      for (int k = 0; k < cnt; k++) begin
        pair_t p;
        int    v;
        v      = -e + 2 * k;
        p.even = int'(mirror(v, nm1) << l);
        p.odd  = int'(mirror(v + 1, nm1) << l);
        p.ch   = c;
        p.ll   = (k == cnt - 1);
        p.lf   = p.ll && (c == chm);
        q.push_back(p);
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every displayed pair with the scoreboard head, pop on accept.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pair_unexpected: got even=%0d odd=%0d ch=%0d, expected no valid",
                 even_line_num_o, odd_line_num_o, ch_o);
      end else begin
        mon_exp = q[0];
        if (even_line_num_o !== mon_exp.even || odd_line_num_o !== mon_exp.odd ||
            int'(ch_o) != mon_exp.ch || last_line_o !== mon_exp.ll ||
            last_frame_o !== mon_exp.lf) begin
          errors++;
          $display("FAIL pair: got (%0d,%0d) ch=%0d ll=%0b lf=%0b expected (%0d,%0d) ch=%0d ll=%0b lf=%0b",
                   even_line_num_o, odd_line_num_o, ch_o, last_line_o, last_frame_o,
                   mon_exp.even, mon_exp.odd, mon_exp.ch, mon_exp.ll, mon_exp.lf);
        end
        if (ready_i && !abort_i && !rst_i) void'(q.pop_front());
      end
    end
  end

  task automatic start_seq(input int nm1, input int e, input int l, input int chm);
    push_model(nm1, e, l, chm);
    vsize_i    = ADDR_W'(nm1);
    ext_i      = EXT_W'(e);
    level_i    = LVL_W'(l);
    channels_i = CH_W'(chm);
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
    chk("start_valid", valid_o, 1);
    chk("start_busy", busy_o, 1);
    // config must already be latched; scramble the inputs
    vsize_i    = ADDR_W'($urandom_range(0, 40));
    ext_i      = EXT_W'($urandom_range(0, 7));
    level_i    = LVL_W'($urandom_range(0, 7));
    channels_i = CH_W'($urandom_range(0, 3));
  endtask

  task automatic drain(input bit rnd, input bit start_at_end);
    int cyc;
    cyc = 0;
    while (q.size() != 0 && cyc < 400) begin
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (start_at_end && q.size() == 1 && ready_i) begin
        vsize_i = 7; ext_i = 4; level_i = 0; channels_i = 0;
        start_i = 1'b1;
      end
      tick();
      start_i = 1'b0;
      cyc++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pairs outstanding expected 0", q.size());
      q.delete();
    end
    chk("end_valid", valid_o, 0);
    chk("end_busy", busy_o, 0);
    ready_i = 1'b1;
    if (start_at_end) begin
      tick();
      chk("ignored_start_valid", valid_o, 0);
      chk("ignored_start_busy", busy_o, 0);
    end
  endtask

  task automatic reject(input int nm1, input int e, input int l);
    vsize_i = ADDR_W'(nm1);
    ext_i   = EXT_W'(e);
    level_i = LVL_W'(l);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("reject_err", cfg_err_o, 1);
    chk("reject_valid", valid_o, 0);
    tick();
    chk("reject_err_pulse", cfg_err_o, 0);
    chk("reject_valid2", valid_o, 0);
    chk("reject_busy", busy_o, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_last_line", last_line_o, 0);
    chk("rst_last_frame", last_frame_o, 0);
    chk("rst_cfg_err", cfg_err_o, 0);
    chk("rst_even", even_line_num_o, 0);
    chk("rst_odd", odd_line_num_o, 0);
    chk("rst_ch", ch_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1;
    vsize_i = '0; ext_i = '0; level_i = '0; channels_i = '0;
    repeat (3) tick();
    chk_reset_vals();
    rst_i = 1'b0;
    tick();

    start_seq(7, EXT_97, 0, 0); drain(0, 0);
    start_seq(7, 3, 1, 0);      drain(0, 0);
    start_seq(6, EXT_53, 0, 2); drain(0, 0);
    start_seq(7, 4, 0, 0);      drain(1, 0);

    reject(0, 0, 0);
    reject(4, 4, 0);
    reject(20, 6, 0);
    reject(20, 2, 6);

    // abort while the 4th pair is displayed, with ready high
    start_seq(7, 4, 0, 0);
    ready_i = 1'b1;
    repeat (3) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    q.delete();
    chk("abort_valid", valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_last_line", last_line_o, 0);
    chk("abort_last_frame", last_frame_o, 0);
    start_seq(7, 4, 0, 0); drain(0, 0);

    // reset mid-sequence
    start_seq(7, 3, 1, 1);
    repeat (4) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    q.delete();
    chk_reset_vals();
    tick();
    chk("post_rst_valid", valid_o, 0);

    // start coinciding with the final accept is ignored
    start_seq(7, 4, 0, 0); drain(0, 1);

    for (int i = 0; i < 12; i++) begin
      int nm1;
      int e;
      nm1 = $urandom_range(1, 20);
      e   = $urandom_range(0, (nm1 - 1 < 5) ? nm1 - 1 : 5);
      start_seq(nm1, e, $urandom_range(0, 5), $urandom_range(0, 3));
      drain(1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_pair_sequencer.md
# line_pair_sequencer

Generates the sequence of (even, odd) line-number pairs that the DMA read engine fetches for one vertical DWT pass, including whole-sample symmetric extension at the top and bottom edges. It sits between the frame controller and the DMA address generator. Extension depth, decomposition level and channel count are runtime inputs, so one instance serves both the 5/3 and 9/7 filters at every level and for every colour component.

## Interface
- ADDR_W, 32: width of line numbers and of `vsize_i`.
- MAX_EXT, 5: largest supported extension depth; `EXT_W = $clog2(MAX_EXT+1)`.
- MAX_LEVEL, 5: largest decomposition level; `LVL_W = $clog2(MAX_LEVEL+1)`.
- MAX_CH, 4: largest channel count; `CH_W = $clog2(MAX_CH)` (minimum 1).

Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  frame start; sampled only when `busy_o = 0`.
- abort_i  in  1  terminates the current sequence.
- vsize_i  in  ADDR_W  lines at this level minus 1 (N-1).
- ext_i  in  EXT_W  extension depth E (2 for 5/3, 4 for 9/7).
- level_i  in  LVL_W  decomposition level L.
- channels_i  in  CH_W  channel count minus 1.
- ready_i  in  1  consumer accepts the current pair.
- valid_o  out  1  pair valid.
- even_line_num_o  out  ADDR_W  full-resolution line of the even sample.
- odd_line_num_o  out  ADDR_W  full-resolution line of the odd sample.
- ch_o  out  CH_W  channel of the current pair.
- last_line_o  out  1  last pair of the current channel.
- last_frame_o  out  1  last pair of the last channel.
- busy_o  out  1  sequence in progress.
- cfg_err_o  out  1  one-cycle pulse when `start_i` is rejected.

## Operation
- The virtual index v is signed, ADDR_W+1 bits wide. The mirror function is m(x) = -x for x<0, 2(N-1)-x for x>N-1, and x otherwise.
- Each pair is (m(v) << L, m(v+1) << L). The sequence starts at v = -E and advances v += 2. The last pair of a channel is the first v with v+1 >= N-1+E. This gives ceil((N+2E)/2) pairs per channel.
- The states are Idle, Top (v<0), Body (0<=v and v+1<=N-1), and Bottom (v+1>N-1). On every accepted pair the state is recomputed from the next value of v. After the last pair of a channel with ch_o < channels, the sequence restarts at v = -E and ch_o increments. After the last pair of the last channel, the block returns to Idle.
- Config checks on `start_i`: the start is rejected if `vsize_i == 0`, if `ext_i >= vsize_i`, if `ext_i > MAX_EXT`, or if `level_i > MAX_LEVEL`. A rejected start pulses `cfg_err_o`, stays in Idle and raises no valid.
- All config is latched on an accepted start. Input changes during a sequence have no effect.
- `abort_i` in a non-Idle state returns the block to Idle on the next cycle. No last flags are raised.
- `last_line_o` and `last_frame_o` are qualified by `valid_o`.

## Timing
- Reset values: state Idle; `valid_o`, `busy_o`, `last_line_o`, `last_frame_o` and `cfg_err_o` are 0; line outputs are 0; `ch_o` is 0.
- All outputs are registered.
- Start latency: `start_i` accepted at cycle t gives `valid_o = 1` with the first pair at t+1. `busy_o` is 1 from t+1 until Idle.
- Handshake: the pair advances only when `valid_o && ready_i`. While `ready_i = 0`, all outputs hold. Throughput is 1 pair/cycle under constant ready.
- On the final accept at cycle t, `valid_o` and `busy_o` are 0 at t+1. A `start_i` at t is ignored (busy); a `start_i` at t+1 is accepted.
- Priority: `rst_i` > `abort_i` > advance. When abort and accept occur in the same cycle, the abort wins.
- `cfg_err_o` asserts in the cycle after the rejected start.

## Structure
- `line_seq_pkg` holds `state_t` (Idle, Top, Body, Bottom), the width localparam helpers, and the constants EXT_53 = 2 and EXT_97 = 4.
- One combinational sub-module, `line_mirror`, takes (v, N-1, L) and returns the shifted line number. It is instantiated twice, once for v+2 and once for v+3, so the next pair is ready for registering.

## Test plan
- N=8 (`vsize_i` 7), E=4, L=0, 1 channel, ready held 1. Required pairs: (4,3) (2,1) (0,1) (2,3) (4,5) (6,7) (6,5) (4,3). `last_line_o` and `last_frame_o` are 1 on the 8th pair only.
- N=8, E=3, L=1. Required pairs: (6,4) (2,0) (2,4) (6,8) (10,12) (14,12) (10,8). That is 7 pairs.
- N=7, E=2, 3 channels (`channels_i` 2). Required pairs per channel: (2,1) (0,1) (2,3) (4,5) (6,5) (4,3). `ch_o` runs 0, 1, 2. `last_line_o` appears 3 times; `last_frame_o` appears once, on the 18th pair.
- Random `ready_i` backpressure on the first case. Outputs must be stable while stalled, and the sequence must be identical to the first case.
- Rejected starts: `vsize_i` 0, and `ext_i` 4 with `vsize_i` 4. Each must give one `cfg_err_o` pulse and no `valid_o`. An `abort_i` after the 3rd pair must give `valid_o` = 0 next cycle, and a restart must begin at (4,3).
- `rst_i` asserted mid-sequence must give all outputs at their reset values the next cycle. `start_i` in the same cycle as the final accept must be ignored.
